// File: rtl/router_pkg.sv
// router_pkg: shared definitions for the router packet transmitter.
//   - state_t      : transmitter FSM states
//   - ADDR_INVALID : destination code that is never accepted
//   - LEN_W        : payload length field width
//   - LFSR_TAPS    : feedback taps of the payload LFSR (bits 7,5,4,3)
//   - lfsr_step()  : one shift of the payload LFSR
package router_pkg;

    localparam int unsigned LEN_W        = 6;
    localparam logic [1:0]  ADDR_INVALID = 2'b11;
    localparam logic [7:0]  LFSR_TAPS    = 8'hB8;
    localparam logic [7:0]  LFSR_NZ_SEED = 8'h01;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        PAYLOAD,
        PARITY,
        ERR_WAIT,
        DONE
    } state_t;

    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/router_tx_lfsr.sv
// router_tx_lfsr: 8-bit payload byte generator.
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous active-high reset, clears q
//   load    - load seed (an all-zero seed is replaced by 8'h01)
//   seed    - seed value
//   advance - shift once
//   q       - current LFSR value
module router_tx_lfsr
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       advance,
    output logic [7:0] q
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= 8'h00;
        end else if (load) begin
            // All-zero is a lock-up state for this LFSR
            q <= (seed == 8'h00) ? LFSR_NZ_SEED : seed;
        end else if (advance) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: sends one packet (header, LFSR payload, parity) into a router
// input port, honouring the router's busy stall, then samples its err flag.
// Ports:
//   clock, reset         - clock (rising edge), asynchronous active-high reset
//   start                - packet request, taken only while cmd_ready=1
//   dest_addr, pkt_len   - destination (0..2) and payload length (1..MAX_LEN)
//   seed                 - payload LFSR seed
//   busy, err            - router stall and router parity error flag
//   cmd_ready            - idle and able to accept start
//   data_out, pkt_valid  - byte to router and header/payload qualifier
//   tx_done, tx_err      - completion pulse, err captured for the last packet
//   inject_err           - only with ROUTER_TX_ERR_INJ_EN: corrupt parity bit 0
// Build option: define ROUTER_TX_ERR_INJ_EN to add the inject_err input.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int unsigned MAX_LEN = 63
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       dest_addr,
    input  logic [LEN_W-1:0] pkt_len,
    input  logic [7:0]       seed,
    input  logic             busy,
    input  logic             err,
    output logic             cmd_ready,
    output logic [7:0]       data_out,
    output logic             pkt_valid,
    output logic             tx_done,
    output logic             tx_err
`ifdef ROUTER_TX_ERR_INJ_EN
    ,
    input  logic             inject_err
`endif
);

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;       // index of the payload byte on data_out
    logic [7:0]       parity_q;    // XOR of all bytes consumed so far
    logic             err_acc_q;
    logic             ew_second_q;
    logic [7:0]       lfsr_q;
    logic             inj_q;
    logic             accept;
    logic             lfsr_adv;

    assign accept = start && (state_q == IDLE) && (dest_addr != ADDR_INVALID) &&
                    (pkt_len != '0) && (32'(pkt_len) <= MAX_LEN);

    // The LFSR runs one byte ahead of data_out so the next byte is ready
    // in lfsr_q at the edge that consumes the current one.
    assign lfsr_adv = !busy && ((state_q == HEADER) ||
                                ((state_q == PAYLOAD) && (cnt_q != len_q)));

    router_tx_lfsr u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .load    (accept),
        .seed    (seed),
        .advance (lfsr_adv),
        .q       (lfsr_q)
    );

`ifdef ROUTER_TX_ERR_INJ_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inj_q <= 1'b0;
        end else if (accept) begin
            inj_q <= inject_err;
        end
    end
`else
    assign inj_q = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cmd_ready   <= 1'b1;
            data_out    <= 8'h00;
            pkt_valid   <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            parity_q    <= 8'h00;
            err_acc_q   <= 1'b0;
            ew_second_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= HEADER;
                        cmd_ready <= 1'b0;
                        data_out  <= {pkt_len, dest_addr};
                        pkt_valid <= 1'b1;
                        tx_err    <= 1'b0;
                        len_q     <= pkt_len;
                        cnt_q     <= '0;
                        parity_q  <= 8'h00;
                    end
                end
                HEADER: begin
                    if (!busy) begin
                        state_q  <= PAYLOAD;
                        parity_q <= data_out;
                        data_out <= lfsr_q;
                        cnt_q    <= LEN_W'(1);
                    end
                end
                PAYLOAD: begin
                    if (!busy) begin
                        parity_q <= parity_q ^ data_out;
                        if (cnt_q == len_q) begin
                            state_q   <= PARITY;
                            pkt_valid <= 1'b0;
                            data_out  <= parity_q ^ data_out ^ {7'b0, inj_q};
                        end else begin
                            data_out <= lfsr_q;
                            cnt_q    <= cnt_q + LEN_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (!busy) begin
                        state_q     <= ERR_WAIT;
                        data_out    <= 8'h00;
                        err_acc_q   <= 1'b0;
                        ew_second_q <= 1'b0;
                    end
                end
                ERR_WAIT: begin
                    if (!ew_second_q) begin
                        ew_second_q <= 1'b1;
                        err_acc_q   <= err;
                    end else begin
                        state_q <= DONE;
                        tx_err  <= err_acc_q | err;
                        tx_done <= 1'b1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    tx_done   <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state_q   <= IDLE;
                    cmd_ready <= 1'b1;
                    data_out  <= 8'h00;
                    pkt_valid <= 1'b0;
                    tx_done   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb_router_pkt_tx: randomized self-checking bench for router_pkt_tx.
// Expected byte streams are built from the packet format rules (header,
// shifted-feedback payload, XOR parity) and replayed against the DUT while
// busy, err and stray start requests are randomized.
// Build option: ROUTER_TX_ERR_INJ_EN also exercises the inject_err input.
module tb_router_pkt_tx;

`ifdef ROUTER_TX_ERR_INJ_EN
    localparam bit INJ_EN = 1'b1;
`else
    localparam bit INJ_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] pkt_len;
    logic [7:0] seed;
    logic       busy;
    logic       err;
    logic       inject_err;
    logic       cmd_ready;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_done;
    logic       tx_err;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clock = ~clock;

    router_pkt_tx dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .dest_addr  (dest_addr),
        .pkt_len    (pkt_len),
        .seed       (seed),
        .busy       (busy),
        .err        (err),
        .cmd_ready  (cmd_ready),
        .data_out   (data_out),
        .pkt_valid  (pkt_valid),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
`ifdef ROUTER_TX_ERR_INJ_EN
        ,
        .inject_err (inject_err)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] next_byte(input logic [7:0] c);
        int fb;
        fb = (c >> 7) ^ (c >> 5) ^ (c >> 4) ^ (c >> 3);
        return 8'(((int'(c) << 1) & 8'hFE) | (fb & 1));
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ready"}, cmd_ready, 1);
        check_eq({tag, "_pv"}, pkt_valid, 0);
        check_eq({tag, "_data"}, data_out, 0);
        check_eq({tag, "_done"}, tx_done, 0);
    endtask

    // busy_mode: 0 never busy, 1 random busy, 2 busy 3 cycles on payload byte 1.
    // rst_at >= 0: assert reset mid-cycle at that transfer cycle and leave it high.
    task automatic send_pkt(input logic [1:0] addr, input logic [5:0] len,
                            input logic [7:0] sd, input logic inj, input int busy_mode,
                            input logic e1, input logic e2, input logic release_rst,
                            input int rst_at);
        logic [7:0] exp_q[$];
        logic [7:0] cur;
        logic [7:0] par;
        int idx;
        int cyc;
        int held;
        logic b;

        exp_q.push_back({len, addr});
        par = {len, addr};
        cur = (sd == 8'h00) ? 8'h01 : sd;
        for (int k = 0; k < int'(len); k++) begin
            exp_q.push_back(cur);
            par ^= cur;
            cur = next_byte(cur);
        end
        exp_q.push_back(par ^ {7'b0, inj & INJ_EN});

        @(negedge clock);
        if (release_rst) reset = 1'b0;
        else check_eq("ready_before_start", cmd_ready, 1);
        start = 1'b1; dest_addr = addr; pkt_len = len; seed = sd;
        inject_err = inj; busy = 1'b0; err = 1'b0;

        idx = 0; cyc = 0; held = 0;
        while (idx < exp_q.size()) begin
            @(negedge clock);
            // Scrambled inputs and stray starts must not disturb the packet
            start = ($urandom_range(0, 3) == 0);
            dest_addr = 2'($urandom); pkt_len = 6'($urandom); seed = 8'($urandom);
            inject_err = 1'($urandom);
            check_eq("data", data_out, exp_q[idx]);
            check_eq("pkt_valid", pkt_valid, (idx < exp_q.size() - 1) ? 1 : 0);
            check_eq("ready_busy", cmd_ready, 0);
            if (cyc == 0) check_eq("tx_err_cleared", tx_err, 0);
            if (rst_at == cyc) begin
                #2 reset = 1'b1;
                #1 check_idle_outputs("reset_mid");
                check_eq("reset_mid_err", tx_err, 0);
                start = 1'b0;
                return;
            end
            if (busy_mode == 1) b = (cyc < 200) && ($urandom_range(0, 2) == 0);
            else if (busy_mode == 2) b = (idx == 1) && (held < 3);
            else b = 1'b0;
            if (idx == 1) held++;
            busy = b;
            if (!b) idx++;
            cyc++;
        end
        if (busy_mode == 2) check_eq("busy_hold_cycles", held, 4);

        @(negedge clock);
        check_eq("ew1_data", data_out, 0);
        check_eq("ew1_pv", pkt_valid, 0);
        check_eq("ew1_ready", cmd_ready, 0);
        busy = 1'($urandom); err = e1; start = 1'($urandom);
        @(negedge clock);
        check_eq("ew2_done", tx_done, 0);
        check_eq("ew2_ready", cmd_ready, 0);
        err = e2; start = 1'($urandom);
        @(negedge clock);
        check_eq("done_pulse", tx_done, 1);
        check_eq("done_tx_err", tx_err, e1 | e2);
        check_eq("done_pv", pkt_valid, 0);
        check_eq("done_data", data_out, 0);
        start = 1'b0; err = 1'b0; busy = 1'b0;
        @(negedge clock);
        check_idle_outputs("post_done");
        check_eq("tx_err_hold", tx_err, e1 | e2);
    endtask

    task automatic try_invalid(input logic [1:0] addr, input logic [5:0] len, input string tag);
        @(negedge clock);
        start = 1'b1; dest_addr = addr; pkt_len = len; seed = 8'($urandom);
        @(negedge clock);
        start = 1'b0;
        check_idle_outputs(tag);
        @(negedge clock);
        check_idle_outputs({tag, "_2"});
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; dest_addr = '0; pkt_len = '0; seed = '0;
        busy = 1'b0; err = 1'b0; inject_err = 1'b0;
        #12;
        check_idle_outputs("reset");
        check_eq("reset_err", tx_err, 0);

        // Start on the very first edge after reset release
        send_pkt(2'd1, 6'd1, 8'h01, 1'b0, 0, 1'b0, 1'b0, 1'b1, -1);
        send_pkt(2'd1, 6'd2, 8'h01, 1'b0, 2, 1'b0, 1'b0, 1'b0, -1);
        send_pkt(2'd2, 6'd5, 8'h3C, 1'b0, 0, 1'b0, 1'b1, 1'b0, -1);
        send_pkt(2'd0, 6'd4, 8'h00, 1'b0, 1, 1'b1, 1'b0, 1'b0, -1);
        if (INJ_EN) send_pkt(2'd1, 6'd1, 8'h01, 1'b1, 0, 1'b0, 1'b0, 1'b0, -1);

        try_invalid(2'd3, 6'd4, "bad_addr");
        try_invalid(2'd1, 6'd0, "bad_len");

        send_pkt(2'd2, 6'd6, 8'hA5, 1'b0, 0, 1'b0, 1'b0, 1'b0, 3);
        send_pkt(2'd2, 6'd3, 8'h5A, 1'b0, 1, 1'b0, 1'b0, 1'b1, -1);
        send_pkt(2'd0, 6'd63, 8'hFF, 1'b0, 1, 1'b0, 1'b0, 1'b0, -1);

        for (int p = 0; p < 40; p++) begin
            send_pkt(2'($urandom_range(0, 2)), 6'($urandom_range(1, 63)), 8'($urandom),
                     1'($urandom), 1, 1'($urandom), 1'($urandom), 1'b0, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
